eth_fcs_strip: RTL and testbench

Receive-side frame checker sitting directly downstream of the GMII MAC receiver, in the `rx_clk` domain. Consumes the MAC's byte-wide AXI-Stream: payload from destination MAC through FCS, no backpressure. Removes the trailing 4-byte FCS and verifies the CRC-32 over the whole frame. Forwards the payload with an error flag on the last beat, and keeps good/bad frame counters.

---
 rtl/eth_pkg.sv | 18 +
 rtl/eth_crc32_d8.sv | 24 ++
 rtl/eth_fcs_strip.sv | 136 +++++++++++++
 tb/tb_eth_fcs_strip.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet constants and types
// used by the receive and transmit FCS blocks.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int ETH_MIN_FRAME = 64;
    localparam int ETH_MAX_FRAME = 1518;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } fcs_state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: one-byte step of the reflected CRC-32,
// LSB-first, no final XOR.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/eth_fcs_strip.sv
// eth_fcs_strip: strips the trailing FCS from received frames,
// checks CRC/length/upstream errors and counts good/bad frames.
module eth_fcs_strip
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_FRAME,
    parameter int MAX_LEN = ETH_MAX_FRAME,
    parameter int CNT_W   = 32
) (
    input  logic             rx_clk,
    input  logic             rst_n,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             frame_good,
    output logic             frame_bad,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [10:0] LEN_SAT = 11'h7FF;

    fcs_state_t       state, state_d;
    logic [3:0][7:0]  dly, dly_d;
    logic [10:0]      len, len_d, len_inc;
    logic [31:0]      crc, crc_d, crc_upd;
    logic             err, err_d, err_fin;
    logic [7:0]       tdata_d;
    logic             tvalid_d, tlast_d, tuser_d;
    logic             good_d, bad_d;
    logic [CNT_W-1:0] good_cnt_d, bad_cnt_d;

    eth_crc32_d8 u_crc (
        .crc      (crc),
        .data     (s_axis_tdata),
        .crc_next (crc_upd)
    );

    assign len_inc = (len == LEN_SAT) ? len : len + 11'd1;

    // Verdict for a frame ending on the current beat.
    assign err_fin = err | s_axis_tuser
                   | (crc_upd != CRC32_RESIDUE)
                   | (int'(len_inc) < MIN_LEN)
                   | (int'(len_inc) > MAX_LEN);

    always_comb begin
        state_d    = state;
        dly_d      = dly;
        len_d      = len;
        crc_d      = crc;
        err_d      = err;
        tdata_d    = m_axis_tdata;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;
        good_d     = 1'b0;
        bad_d      = 1'b0;
        good_cnt_d = good_cnt;
        bad_cnt_d  = bad_cnt;

        if (s_axis_tvalid) begin
            if (state == STREAM) begin
                tvalid_d = 1'b1;
                tdata_d  = dly[3];
            end
            if (s_axis_tlast) begin
                state_d = IDLE;
                dly_d   = '0;
                len_d   = '0;
                crc_d   = CRC32_INIT;
                err_d   = 1'b0;
                if (state == STREAM) begin
                    tlast_d = 1'b1;
                    tuser_d = err_fin;
                    good_d  = ~err_fin;
                    bad_d   = err_fin;
                end else begin
                    bad_d = 1'b1;
                end
            end else begin
                dly_d = {dly[2:0], s_axis_tdata};
                len_d = len_inc;
                crc_d = crc_upd;
                err_d = err | s_axis_tuser;
                unique case (state)
                    IDLE:   state_d = FILL;
                    FILL:   if (len_inc == 11'd4) state_d = STREAM;
                    STREAM: state_d = STREAM;
                    default: state_d = IDLE;
                endcase
            end
        end

        if (good_d) good_cnt_d = good_cnt + CNT_W'(1);
        if (bad_d)  bad_cnt_d  = bad_cnt + CNT_W'(1);
    end

    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            dly           <= '0;
            len           <= '0;
            crc           <= CRC32_INIT;
            err           <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_good    <= 1'b0;
            frame_bad     <= 1'b0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
        end else begin
            state         <= state_d;
            dly           <= dly_d;
            len           <= len_d;
            crc           <= crc_d;
            err           <= err_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            m_axis_tuser  <= tuser_d;
            frame_good    <= good_d;
            frame_bad     <= bad_d;
            good_cnt      <= good_cnt_d;
            bad_cnt       <= bad_cnt_d;
        end
    end

endmodule

// File: tb/tb_eth_fcs_strip.sv
// tb_eth_fcs_strip: frame-level scoreboard bench; two DUTs
// (MIN_LEN 13 and default 64) see the same stream.
module tb_eth_fcs_strip;

    typedef logic [7:0] bq_t [$];

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       u;
        logic       g;
        logic       b;
    } beat_t;

    typedef struct {
        int plen;
        bit fcs_ok;
        int user_at;
        int gmin;
        int gmax;
        bit bad_a;
        bit bad_b;
    } vec_t;

    localparam int MIN_A = 13;
    localparam int MAX_L = 1518;
    localparam int NV    = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_d;
    logic        in_v, in_l, in_u;
    logic [1:0]  o_v, o_l, o_u, o_g, o_b;
    logic [7:0]  o_d [2];
    logic [31:0] o_gc [2];
    logic [31:0] o_bc [2];

    beat_t       exp_n [2];
    beat_t       exp_q [2];
    logic [31:0] gc_n [2];
    logic [31:0] bc_n [2];
    logic [31:0] gc_q [2];
    logic [31:0] bc_q [2];
    bit          mon_en = 1'b0;
    int          good_seen [2] = '{0, 0};
    int          bad_seen [2]  = '{0, 0};
    int          beat_seen [2] = '{0, 0};
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    eth_fcs_strip #(.MIN_LEN(MIN_A)) dut_a (
        .rx_clk        (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (in_d),
        .s_axis_tvalid (in_v),
        .s_axis_tlast  (in_l),
        .s_axis_tuser  (in_u),
        .m_axis_tdata  (o_d[0]),
        .m_axis_tvalid (o_v[0]),
        .m_axis_tlast  (o_l[0]),
        .m_axis_tuser  (o_u[0]),
        .frame_good    (o_g[0]),
        .frame_bad     (o_b[0]),
        .good_cnt      (o_gc[0]),
        .bad_cnt       (o_bc[0])
    );

    eth_fcs_strip dut_b (
        .rx_clk        (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (in_d),
        .s_axis_tvalid (in_v),
        .s_axis_tlast  (in_l),
        .s_axis_tuser  (in_u),
        .m_axis_tdata  (o_d[1]),
        .m_axis_tvalid (o_v[1]),
        .m_axis_tlast  (o_l[1]),
        .m_axis_tuser  (o_u[1]),
        .frame_good    (o_g[1]),
        .frame_bad     (o_b[1]),
        .good_cnt      (o_gc[1]),
        .bad_cnt       (o_bc[1])
    );

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h @%0t", nm, k, act, want, $time);
        end
    endtask

    function automatic int min_of(input int k);
        return (k == 0) ? MIN_A : 64;
    endfunction

    // Standard Ethernet FCS of the first n bytes.
    function automatic logic [31:0] eth_fcs(input bq_t d, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, d[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t make_frame(input int plen, input bit inc, input bit ok);
        bq_t q;
        logic [31:0] f;
        for (int i = 0; i < plen; i++)
            q.push_back(inc ? 8'(i) : 8'($urandom));
        f = eth_fcs(q, plen);
        if (!ok) f = f ^ 32'h0100_0000;
        q.push_back(f[7:0]);
        q.push_back(f[15:8]);
        q.push_back(f[23:16]);
        q.push_back(f[31:24]);
        return q;
    endfunction

    always @(posedge clk) begin
        exp_q <= exp_n;
        gc_q  <= gc_n;
        bc_q  <= bc_n;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("tvalid", k, 32'(o_v[k]), 32'(exp_q[k].v));
                if (exp_q[k].v) begin
                    chk("tdata", k, 32'(o_d[k]), 32'(exp_q[k].d));
                    chk("tlast", k, 32'(o_l[k]), 32'(exp_q[k].l));
                    if (exp_q[k].l)
                        chk("tuser", k, 32'(o_u[k]), 32'(exp_q[k].u));
                end
                chk("frame_good", k, 32'(o_g[k]), 32'(exp_q[k].g));
                chk("frame_bad", k, 32'(o_b[k]), 32'(exp_q[k].b));
                chk("good_cnt", k, o_gc[k], gc_q[k]);
                chk("bad_cnt", k, o_bc[k], bc_q[k]);
                if (o_g[k]) good_seen[k]++;
                if (o_b[k]) bad_seen[k]++;
                if (o_v[k]) beat_seen[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_beat();
        in_v = 1'b0;
        in_l = 1'b0;
        in_u = 1'b0;
        in_d = 8'h00;
        exp_n[0] = '0;
        exp_n[1] = '0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_v  = 1'b0;
        in_l  = 1'b0;
        in_u  = 1'b0;
        in_d  = 8'h00;
        for (int k = 0; k < 2; k++) begin
            exp_n[k] = '0;
            gc_n[k]  = '0;
            bc_n[k]  = '0;
        end
        tick();
        rst_n = 1'b1;
    endtask

    // trunc > 0 sends only the first trunc bytes, without tlast.
    task automatic send_frame(input bq_t d, input int user_at,
                              input int gmin, input int gmax, input int trunc);
        int   n;
        int   nb;
        logic fcs_ok;
        logic uerr;
        logic last;
        logic bad [2];
        n  = d.size();
        nb = (trunc > 0) ? trunc : n;
        fcs_ok = 1'b0;
        if (n >= 4)
            fcs_ok = (eth_fcs(d, n - 4) == {d[n-1], d[n-2], d[n-3], d[n-4]});
        uerr = (user_at >= 0) && (user_at < nb);
        for (int k = 0; k < 2; k++)
            bad[k] = uerr || !fcs_ok || (n < min_of(k)) || (n > MAX_L) || (n <= 4);
        for (int i = 0; i < nb; i++) begin
            if (i > 0) repeat ($urandom_range(gmax, gmin)) idle_beat();
            last = (trunc == 0) && (i == n - 1);
            in_v = 1'b1;
            in_d = d[i];
            in_l = last;
            in_u = (i == user_at);
            for (int k = 0; k < 2; k++) begin
                exp_n[k] = '0;
                if (i >= 4) begin
                    exp_n[k].v = 1'b1;
                    exp_n[k].d = d[i-4];
                    exp_n[k].l = last;
                    exp_n[k].u = last & bad[k];
                end
                if (last) begin
                    if (bad[k]) begin
                        exp_n[k].b = 1'b1;
                        bc_n[k] = bc_n[k] + 1;
                    end else begin
                        exp_n[k].g = 1'b1;
                        gc_n[k] = gc_n[k] + 1;
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        vec_t tv [NV];
        bq_t  fr;
        int   g0 [2];
        int   b0 [2];
        int   n0 [2];
        int   plen;

        tv[0]  = '{60,   1'b1, -1, 1, 3, 1'b0, 1'b0};
        tv[1]  = '{59,   1'b1, -1, 0, 2, 1'b0, 1'b1};
        tv[2]  = '{6,    1'b1, -1, 0, 0, 1'b1, 1'b1};
        tv[3]  = '{9,    1'b1, -1, 0, 1, 1'b0, 1'b1};
        tv[4]  = '{8,    1'b1, -1, 0, 0, 1'b1, 1'b1};
        tv[5]  = '{100,  1'b0, -1, 0, 2, 1'b1, 1'b1};
        tv[6]  = '{100,  1'b1, 50, 0, 2, 1'b1, 1'b1};
        tv[7]  = '{1514, 1'b1, -1, 0, 0, 1'b0, 1'b0};
        tv[8]  = '{1515, 1'b1, -1, 0, 0, 1'b1, 1'b1};
        tv[9]  = '{1,    1'b1, -1, 0, 1, 1'b1, 1'b1};
        tv[10] = '{0,    1'b1, -1, 0, 1, 1'b1, 1'b1};
        tv[11] = '{64,   1'b1, 67, 0, 0, 1'b1, 1'b1};

        do_reset();
        mon_en = 1'b1;
        idle_beat();

        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
               8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(fr, -1, 0, 0, 0);
        idle_beat();
        chk("lit_good_cnt", 0, o_gc[0], 32'd1);
        chk("lit_beats", 0, 32'(beat_seen[0]), 32'd9);

        fr[12] = 8'hCA;
        send_frame(fr, -1, 0, 0, 0);
        idle_beat();
        chk("corrupt_bad_cnt", 0, o_bc[0], 32'd1);
        chk("corrupt_beats", 0, 32'(beat_seen[0]), 32'd18);

        n0[0] = beat_seen[0];
        fr = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(fr, -1, 0, 0, 0);
        idle_beat();
        chk("runt3_beats", 0, 32'(beat_seen[0] - n0[0]), 32'd0);
        chk("runt3_bad_cnt", 0, o_bc[0], 32'd2);

        do_reset();
        send_frame(make_frame(70, 1'b0, 1'b1), 30, 0, 1, 0);
        send_frame(make_frame(70, 1'b0, 1'b1), -1, 0, 0, 0);
        idle_beat();
        for (int k = 0; k < 2; k++) begin
            chk("b2b_good_cnt", k, o_gc[k], 32'd1);
            chk("b2b_bad_cnt", k, o_bc[k], 32'd1);
        end

        for (int k = 0; k < 2; k++) begin
            g0[k] = good_seen[k];
            b0[k] = bad_seen[k];
        end
        send_frame(make_frame(100, 1'b0, 1'b1), -1, 0, 0, 20);
        do_reset();
        idle_beat();
        for (int k = 0; k < 2; k++) begin
            chk("rst_pulses", k, 32'(good_seen[k] + bad_seen[k] - g0[k] - b0[k]), 32'd0);
            chk("rst_good_cnt", k, o_gc[k], 32'd0);
        end
        send_frame(make_frame(60, 1'b1, 1'b1), -1, 0, 0, 0);
        idle_beat();
        for (int k = 0; k < 2; k++)
            chk("post_rst_good_cnt", k, o_gc[k], 32'd1);

        for (int t = 0; t < NV; t++) begin
            for (int k = 0; k < 2; k++) begin
                g0[k] = good_seen[k];
                b0[k] = bad_seen[k];
                n0[k] = beat_seen[k];
            end
            send_frame(make_frame(tv[t].plen, 1'b1, tv[t].fcs_ok),
                       tv[t].user_at, tv[t].gmin, tv[t].gmax, 0);
            idle_beat();
            idle_beat();
            for (int k = 0; k < 2; k++) begin
                logic eb;
                eb = (k == 0) ? tv[t].bad_a : tv[t].bad_b;
                chk("vec_bad", k, 32'(bad_seen[k] - b0[k]), 32'(eb));
                chk("vec_good", k, 32'(good_seen[k] - g0[k]), 32'(!eb));
                chk("vec_beats", k, 32'(beat_seen[k] - n0[k]), 32'(tv[t].plen));
            end
        end

        for (int r = 0; r < 30; r++) begin
            plen = $urandom_range(0, 80);
            send_frame(make_frame(plen, 1'b0, $urandom_range(0, 3) != 0),
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, plen + 3)) : -1,
                       0, 2, 0);
            if ($urandom_range(0, 1) == 1) idle_beat();
        end
        idle_beat();
        idle_beat();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
